// File: rtl/frame_reception.sv
// rtl/frame_reception.sv - byte-stream MAC frame receiver with field extraction; optional ADDR_FILTER_EN
module frame_reception #(
  parameter int unsigned MIN_PREAMBLE = 7,
  parameter logic [7:0]  FCS_BYTE     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic [47:0] local_addr,
  output logic [47:0] dest_addr,
  output logic [47:0] src_addr,
  output logic [15:0] eth_type,
  output logic [31:0] data_out,
  output logic        rx_valid,
  output logic        rx_error,
  output logic        rx_busy,
  output logic [15:0] good_frames
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DEST, SRC, TYPE, PAYLOAD, FCS, DROP
  } state_t;

  localparam int unsigned   PW      = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(MIN_PREAMBLE);

  state_t        state_q, state_d;
  logic [PW-1:0] pre_cnt_q;
  logic [2:0]    byte_cnt_q;
  logic [47:0]   dest_sh_q, src_sh_q;
  logic [15:0]   type_sh_q;
  logic [31:0]   pay_sh_q;
  logic [47:0]   dest_addr_q, src_addr_q;
  logic [15:0]   eth_type_q, good_q;
  logic [31:0]   data_out_q;
  logic          rx_valid_q, rx_error_q, rx_busy_q;

  logic is_pre, is_sfd, fcs_ok, addr_ok, in_frame, commit_d, error_d;

  assign is_pre   = (rx_data == 8'h55);
  assign is_sfd   = (rx_data == 8'hD5);
  assign fcs_ok   = (rx_data == FCS_BYTE);
  assign in_frame = (state_q == DEST) || (state_q == SRC) || (state_q == TYPE) ||
                    (state_q == PAYLOAD) || (state_q == FCS);

`ifdef ADDR_FILTER_EN
  assign addr_ok = (dest_sh_q == local_addr) || (dest_sh_q == 48'hFFFF_FFFF_FFFF);
`else
  logic unused_local_addr;
  assign unused_local_addr = ^local_addr;
  assign addr_ok = 1'b1;
`endif

  // Filtered-out frames end silently: neither a commit nor an error.
  assign commit_d = (state_q == FCS) && rx_dv && fcs_ok && addr_ok;
  assign error_d  = (in_frame && !rx_dv) ||
                    ((state_q == FCS) && rx_dv && !fcs_ok) ||
                    ((state_q == PREAMBLE) && rx_dv && !is_pre &&
                     !(is_sfd && (pre_cnt_q >= PRE_MAX)));

  // Next-state selection; a dropped strobe mid-frame always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_dv && is_pre) state_d = PREAMBLE;
      PREAMBLE: begin
        if (!rx_dv)                               state_d = IDLE;
        else if (is_pre)                          state_d = PREAMBLE;
        else if (is_sfd && pre_cnt_q >= PRE_MAX)  state_d = DEST;
        else                                      state_d = DROP;
      end
      DEST:     if (!rx_dv) state_d = IDLE; else if (byte_cnt_q == 3'd5) state_d = SRC;
      SRC:      if (!rx_dv) state_d = IDLE; else if (byte_cnt_q == 3'd5) state_d = TYPE;
      TYPE:     if (!rx_dv) state_d = IDLE; else if (byte_cnt_q == 3'd1) state_d = PAYLOAD;
      PAYLOAD:  if (!rx_dv) state_d = IDLE; else if (byte_cnt_q == 3'd3) state_d = FCS;
      FCS:      state_d = IDLE;
      DROP:     if (!rx_dv) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, counters, shadow shifting and the registered commit/pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      dest_sh_q   <= '0;
      src_sh_q    <= '0;
      type_sh_q   <= '0;
      pay_sh_q    <= '0;
      dest_addr_q <= '0;
      src_addr_q  <= '0;
      eth_type_q  <= '0;
      data_out_q  <= '0;
      good_q      <= '0;
      rx_valid_q  <= 1'b0;
      rx_error_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_busy_q  <= (state_d != IDLE);
      rx_valid_q <= commit_d;
      rx_error_q <= error_d;
      byte_cnt_q <= (state_d != state_q) ? 3'd0 : byte_cnt_q + {2'b00, rx_dv};
      if (rx_dv) begin
        if (state_q == IDLE)
          pre_cnt_q <= PW'(1);
        else if (state_q == PREAMBLE && is_pre && pre_cnt_q != PRE_MAX)
          pre_cnt_q <= pre_cnt_q + PW'(1);
        if (state_q == DEST)    dest_sh_q <= {dest_sh_q[39:0], rx_data};
        if (state_q == SRC)     src_sh_q  <= {src_sh_q[39:0], rx_data};
        if (state_q == TYPE)    type_sh_q <= {type_sh_q[7:0], rx_data};
        if (state_q == PAYLOAD) pay_sh_q  <= {pay_sh_q[23:0], rx_data};
      end
      if (commit_d) begin
        dest_addr_q <= dest_sh_q;
        src_addr_q  <= src_sh_q;
        eth_type_q  <= type_sh_q;
        data_out_q  <= pay_sh_q;
        if (good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      end
    end
  end

  assign dest_addr   = dest_addr_q;
  assign src_addr    = src_addr_q;
  assign eth_type    = eth_type_q;
  assign data_out    = data_out_q;
  assign rx_valid    = rx_valid_q;
  assign rx_error    = rx_error_q;
  assign rx_busy     = rx_busy_q;
  assign good_frames = good_q;

endmodule

// File: tb/tb_frame_reception.sv
// tb/tb_frame_reception.sv - scoreboard bench for frame_reception
module tb_frame_reception;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic [47:0] local_addr;
  logic [47:0] dest_addr, src_addr;
  logic [15:0] eth_type, good_frames;
  logic [31:0] data_out;
  logic        rx_valid, rx_error, rx_busy;

  frame_reception dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_dv(rx_dv),
    .local_addr(local_addr), .dest_addr(dest_addr), .src_addr(src_addr),
    .eth_type(eth_type), .data_out(data_out), .rx_valid(rx_valid),
    .rx_error(rx_error), .rx_busy(rx_busy), .good_frames(good_frames)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          err;
    bit          busy;
    int          cyc;
    logic [47:0] d, s;
    logic [15:0] t, g;
    logic [31:0] p;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [47:0] m_d = '0, m_s = '0;
  logic [15:0] m_t = '0, m_g = '0;
  logic [31:0] m_p = '0;

  function automatic bit addr_ok(input logic [47:0] d);
`ifdef ADDR_FILTER_EN
    return (d == local_addr) || (d == 48'hFFFF_FFFF_FFFF);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] body_byte(input logic [151:0] body, input int i);
    return body[151 - 8*i -: 8];
  endfunction

  task automatic drive(input logic [7:0] b, input logic dv);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_dv   = dv;
  endtask

  // Called right after driving the byte that triggers the pulse.
  task automatic push(input bit err, input bit busy);
    exp_t e;
    e.err = err; e.busy = busy; e.cyc = cyc + 1;
    e.d = m_d; e.s = m_s; e.t = m_t; e.p = m_p; e.g = m_g;
    sb.push_back(e);
  endtask

  task automatic send_frame(input int pre, input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] t, input logic [31:0] p, input logic [7:0] fcs,
                            input int n_after, input bit gap_dv);
    logic [151:0] body;
    body = {d, s, t, p, fcs};
    for (int i = 0; i < pre; i++) drive(8'h55, 1'b1);
    drive(8'hD5, 1'b1);
    if (pre < 7) begin
      push(1'b1, 1'b1);
      for (int i = 0; i < n_after; i++) drive(body_byte(body, i), 1'b1);
    end else begin
      for (int i = 0; i < n_after; i++) drive(body_byte(body, i), 1'b1);
      if (n_after < 19) begin
        drive(8'h00, 1'b0);
        push(1'b1, 1'b0);
      end else if (fcs != 8'hFF) begin
        push(1'b1, 1'b0);
      end else if (addr_ok(d)) begin
        m_d = d; m_s = s; m_t = t; m_p = p;
        if (m_g != 16'hFFFF) m_g = m_g + 16'd1;
        push(1'b0, 1'b0);
      end
    end
    drive(8'h00, gap_dv);
  endtask

  // Every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rx_valid || rx_error) begin
      if (sb.size() == 0) begin
        chk("spurious", {62'd0, rx_valid, rx_error}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("kind", {62'd0, rx_valid, rx_error}, mon_e.err ? 64'd1 : 64'd2);
        chk("latency", 64'(cyc), 64'(mon_e.cyc));
        chk("busy", 64'(rx_busy), 64'(mon_e.busy));
        chk("dest", dest_addr, mon_e.d);
        chk("src", src_addr, mon_e.s);
        chk("type", eth_type, mon_e.t);
        chk("payload", data_out, mon_e.p);
        chk("good", good_frames, mon_e.g);
      end
    end
  end

  localparam logic [47:0] DA = 48'h0A0B0C0D0E0F, SA = 48'h112233445566;
  localparam logic [47:0] DB = 48'h665544332211, SB = 48'hA1A2A3A4A5A6;
  localparam logic [47:0] DC = 48'hFFFFFFFFFFFF, SC = 48'h0000000000AA;
  localparam logic [47:0] SD = 48'h123456789ABC;

  task automatic check_zero(input string tag);
    chk({tag, "_dest"}, dest_addr, 64'd0);
    chk({tag, "_src"}, src_addr, 64'd0);
    chk({tag, "_type"}, eth_type, 64'd0);
    chk({tag, "_data"}, data_out, 64'd0);
    chk({tag, "_good"}, good_frames, 64'd0);
    chk({tag, "_pulses"}, {61'd0, rx_valid, rx_error, rx_busy}, 64'd0);
  endtask

  initial begin
    logic [151:0] body;
    rst_n      = 1'b0;
    rx_dv      = 1'b0;
    rx_data    = 8'h00;
    local_addr = 48'h000000000001;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    send_frame(7, DA, SA, 16'h0800, 32'hDEADBEEF, 8'hFF, 19, 1'b0);
    send_frame(7, DA, SA, 16'h0800, 32'hDEADBEEF, 8'h00, 19, 1'b0);
    send_frame(7, DA, SA, 16'h0800, 32'hDEADBEEF, 8'hFF, 17, 1'b0);
    send_frame(7, DB, SB, 16'h86DD, 32'h01020304, 8'hFF, 19, 1'b0);
    send_frame(5, DA, SA, 16'h0800, 32'hDEADBEEF, 8'hFF, 19, 1'b0);
    send_frame(7, DA, SD, 16'h88CC, 32'h55D555D5, 8'hFF, 19, 1'b0);
    send_frame(7, DC, SC, 16'h0806, 32'hCAFEF00D, 8'hFF, 19, 1'b1);
    send_frame(7, DA, SA, 16'h0800, 32'hDEADBEEF, 8'hFF, 19, 1'b0);
    send_frame(9, DB, SB, 16'h86DD, 32'h01020304, 8'hFF, 19, 1'b0);

    // Reset asserted for one cycle while the source field is arriving.
    body = {DB, SB, 16'h86DD, 32'h01020304, 8'hFF};
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1);
    drive(8'hD5, 1'b1);
    for (int i = 0; i < 9; i++) drive(body_byte(body, i), 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_dv = 1'b0;
    @(posedge clk);
    #1;
    check_zero("midreset");
    chk("midreset_pending", 64'(sb.size()), 64'd0);
    rst_n = 1'b1;
    m_d = '0; m_s = '0; m_t = '0; m_p = '0; m_g = '0;

    send_frame(7, DC, SC, 16'h0806, 32'hCAFEF00D, 8'hFF, 19, 1'b0);
    send_frame(7, DA, SA, 16'h0800, 32'hDEADBEEF, 8'hFF, 19, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
    chk("final_good", good_frames, m_g);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
